// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux select arbiter and neighbouring channel stages:
// channel count, select width, FSM encoding and one-hot/index conversion.
package mux_sel_arbiter_pkg;

   localparam int N_CH  = 4;
   localparam int SEL_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic logic [N_CH-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
      logic [N_CH-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_CH-1:0] oh);
      logic [SEL_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (oh[i]) idx = SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_sel_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requesting channel at or above ptr,
// wrapping modulo the channel count.
module rr_pick4
   import mux_sel_arbiter_pkg::*;
(
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand;

   // Scan from the farthest candidate back to ptr so the nearest one wins.
   always_comb begin
      found = 1'b0;
      idx   = ptr;
      cand  = ptr;
      for (int k = N_CH - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Four-channel round-robin arbiter driving the select lines of a 4:1 data mux,
// with grant release, request-drop and hold-timeout handover.
module mux_sel_arbiter
   import mux_sel_arbiter_pkg::*;
#(
   parameter int HOLD_MAX = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  req,
   input  logic             rel,
   output logic [N_CH-1:0]  grant,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output state_t           state_dbg
);

   // Handshake: a channel holds req[i] high for as long as it wants the mux;
   // grant[i] is its ready, and the mux path belongs to it while both are high.
   // rel ends the current holder's grant early and is ignored while idle.

   localparam int TW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
   localparam logic [TW-1:0] T_LAST = TW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

   state_t           state, state_n;
   logic [N_CH-1:0]  grant_n;
   logic [SEL_W-1:0] sel_n;
   logic             busy_n;
   logic [SEL_W-1:0] ptr, ptr_n;
   logic [TW-1:0]    timer, timer_n;

   logic [SEL_W-1:0] pick_ptr;
   logic             win_found;
   logic [SEL_W-1:0] win_idx;
   logic             timeout;
   logic             end_ev;

   // While granted, the holder is sel, so the next search starts one past it.
   assign pick_ptr = (state == ST_GRANT) ? sel + SEL_W'(1) : ptr;

   rr_pick4 u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .found (win_found),
      .idx   (win_idx)
   );

   assign timeout   = (HOLD_MAX != 0) && (timer == T_LAST);
   assign end_ev    = rel | ~req[sel] | timeout;
   assign state_dbg = state;

   always_comb begin
      state_n = state;
      grant_n = grant;
      sel_n   = sel;
      busy_n  = busy;
      ptr_n   = ptr;
      timer_n = timer;
      case (state)
         ST_IDLE: begin
            grant_n = '0;
            busy_n  = 1'b0;
            if (win_found) begin
               state_n = ST_GRANT;
               grant_n = idx_to_onehot(win_idx);
               sel_n   = win_idx;
               busy_n  = 1'b1;
               timer_n = '0;
            end
         end
         ST_GRANT: begin
            if (end_ev) begin
               ptr_n   = sel + SEL_W'(1);
               timer_n = '0;
               if (win_found) begin
                  grant_n = idx_to_onehot(win_idx);
                  sel_n   = win_idx;
               end else begin
                  state_n = ST_IDLE;
                  grant_n = '0;
                  busy_n  = 1'b0;
               end
            end else if (HOLD_MAX != 0) begin
               timer_n = timer + TW'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
            grant_n = '0;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         grant <= '0;
         sel   <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
         timer <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         sel   <= sel_n;
         busy  <= busy_n;
         ptr   <= ptr_n;
         timer <= timer_n;
      end
   end

endmodule
